trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 170 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / MRET sequencer between commit, CSR unit and fetch
module trap_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] badaddr_i,
    input  logic        exc_instr_misaligned_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_ecall_i,
    input  logic        exc_load_misaligned_i,
    input  logic        exc_store_misaligned_i,
    input  logic        mret_i,
    input  logic        mtime_exc_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        redirect_ready_i,
    output logic        stall_o,
    output logic        jumpingToMtvec_o,
    output logic [31:0] excCause_o,
    output logic [31:0] trapInfo_o,
    output logic [31:0] trap_pc_o,
    output logic        mret_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRAP     = 2'd1,
        S_MRET     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cause;
    logic [31:0] r_info;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;

    logic        w_trap;
    logic [31:0] w_cause;
    logic [31:0] w_info;
    logic        w_detect;
    logic        w_take_trap;
    logic        w_take_mret;

    // Priority encoder: interrupt first, then synchronous exceptions in fixed order
    always_comb begin
        w_trap  = 1'b0;
        w_cause = 32'h0;
        w_info  = 32'h0;
        if (mtime_exc_i) begin
            w_trap  = 1'b1;
            w_cause = 32'h8000_0007;
        end else if (exc_instr_misaligned_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd0;
            w_info  = badaddr_i;
        end else if (exc_illegal_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd2;
            w_info  = instr_i;
        end else if (exc_ebreak_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd3;
        end else if (exc_ecall_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd11;
        end else if (exc_load_misaligned_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd4;
            w_info  = badaddr_i;
        end else if (exc_store_misaligned_i) begin
            w_trap  = 1'b1;
            w_cause = 32'd6;
            w_info  = badaddr_i;
        end
    end

    // Events only count at the commit boundary in IDLE; reset masks the combinational stall path
    assign w_detect    = rst && (r_state == S_IDLE) && instr_valid_i;
    assign w_take_trap = w_detect && w_trap;
    assign w_take_mret = w_detect && !w_trap && mret_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture trap cause, info and the PC that mepc must receive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cause <= 32'h0;
            r_info  <= 32'h0;
            r_pc    <= 32'h0;
        end else if (w_take_trap) begin
            r_cause <= w_cause;
            r_info  <= w_info;
            r_pc    <= pc_i;
        end
    end

    // Latch the redirect target during the strobe cycle so it stays stable while fetch stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect_pc <= 32'h0;
        end else if (r_state == S_TRAP) begin
            r_redirect_pc <= mtvec_i & 32'hFFFF_FFFC;
        end else if (r_state == S_MRET) begin
            r_redirect_pc <= mepc_i;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next           = r_state;
        stall_o          = 1'b0;
        jumpingToMtvec_o = 1'b0;
        excCause_o       = 32'h0;
        trapInfo_o       = 32'h0;
        trap_pc_o        = 32'h0;
        mret_o           = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                if (w_take_trap) begin
                    stall_o = 1'b1;
                    w_next  = S_TRAP;
                end else if (w_take_mret) begin
                    stall_o = 1'b1;
                    w_next  = S_MRET;
                end
            end
            S_TRAP: begin
                stall_o          = 1'b1;
                jumpingToMtvec_o = 1'b1;
                excCause_o       = r_cause;
                trapInfo_o       = r_info;
                trap_pc_o        = r_pc;
                w_next           = S_REDIRECT;
            end
            S_MRET: begin
                stall_o = 1'b1;
                mret_o  = 1'b1;
                w_next  = S_REDIRECT;
            end
            S_REDIRECT: begin
                stall_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = r_redirect_pc;
                if (redirect_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard testbench for trap_sequencer
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid_i;
    logic [31:0] pc_i, instr_i, badaddr_i;
    logic        exc_instr_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
    logic        exc_load_misaligned_i, exc_store_misaligned_i;
    logic        mret_i, mtime_exc_i;
    logic [31:0] mtvec_i, mepc_i;
    logic        redirect_ready_i;
    logic        stall_o, jumpingToMtvec_o, mret_o, redirect_valid_o;
    logic [31:0] excCause_o, trapInfo_o, trap_pc_o, redirect_pc_o;

    trap_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .instr_valid_i          (instr_valid_i),
        .pc_i                   (pc_i),
        .instr_i                (instr_i),
        .badaddr_i              (badaddr_i),
        .exc_instr_misaligned_i (exc_instr_misaligned_i),
        .exc_illegal_i          (exc_illegal_i),
        .exc_ebreak_i           (exc_ebreak_i),
        .exc_ecall_i            (exc_ecall_i),
        .exc_load_misaligned_i  (exc_load_misaligned_i),
        .exc_store_misaligned_i (exc_store_misaligned_i),
        .mret_i                 (mret_i),
        .mtime_exc_i            (mtime_exc_i),
        .mtvec_i                (mtvec_i),
        .mepc_i                 (mepc_i),
        .redirect_ready_i       (redirect_ready_i),
        .stall_o                (stall_o),
        .jumpingToMtvec_o       (jumpingToMtvec_o),
        .excCause_o             (excCause_o),
        .trapInfo_o             (trapInfo_o),
        .trap_pc_o              (trap_pc_o),
        .mret_o                 (mret_o),
        .redirect_valid_o       (redirect_valid_o),
        .redirect_pc_o          (redirect_pc_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = trap strobe, 1 = mret strobe, 2 = accepted redirect
    typedef struct {
        int          kind;
        logic [31:0] cause;
        logic [31:0] info;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] cause, input logic [31:0] info,
                        input logic [31:0] pc);
        exp_t e;
        e.kind  = kind;
        e.cause = cause;
        e.info  = info;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or an accepted redirect
    logic        mon_wait = 1'b0;
    logic [31:0] mon_pc   = 32'h0;
    always @(negedge clk) begin
        if (!rst) begin
            mon_wait = 1'b0;
        end else begin
            if (jumpingToMtvec_o && mret_o)
                chk("strobe_overlap", 32'd1, 32'd0);
            if (!jumpingToMtvec_o)
                chk("trap_fields_zero", excCause_o | trapInfo_o | trap_pc_o, 32'h0);
            if (mon_wait && redirect_valid_o)
                chk("redirect_stable", redirect_pc_o, mon_pc);
            if (jumpingToMtvec_o || mret_o || (redirect_valid_o && redirect_ready_i)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: trap=%0b mret=%0b redirect=%0b pc=0x%08h expected none",
                             jumpingToMtvec_o, mret_o, redirect_valid_o, redirect_pc_o);
                end else begin
                    exp_t e;
                    int   kact;
                    e    = sb.pop_front();
                    kact = jumpingToMtvec_o ? 0 : (mret_o ? 1 : 2);
                    chk("output_kind", 32'(kact), 32'(e.kind));
                    if (kact == 0) begin
                        chk("excCause", excCause_o, e.cause);
                        chk("trapInfo", trapInfo_o, e.info);
                        chk("trap_pc", trap_pc_o, e.pc);
                    end else if (kact == 2) begin
                        chk("redirect_pc", redirect_pc_o, e.pc);
                    end
                end
            end
            mon_wait = redirect_valid_o && !redirect_ready_i;
            mon_pc   = redirect_pc_o;
        end
    end

    task automatic clear_events();
        instr_valid_i          = 1'b0;
        exc_instr_misaligned_i = 1'b0;
        exc_illegal_i          = 1'b0;
        exc_ebreak_i           = 1'b0;
        exc_ecall_i            = 1'b0;
        exc_load_misaligned_i  = 1'b0;
        exc_store_misaligned_i = 1'b0;
        mret_i                 = 1'b0;
        mtime_exc_i            = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // f = {mtime, instr_mis, illegal, ebreak, ecall, load_mis, store_mis}; called just after a rising edge
    task automatic issue(input logic [6:0] f, input logic m, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] bad);
        instr_valid_i          = 1'b1;
        mtime_exc_i            = f[6];
        exc_instr_misaligned_i = f[5];
        exc_illegal_i          = f[4];
        exc_ebreak_i           = f[3];
        exc_ecall_i            = f[2];
        exc_load_misaligned_i  = f[1];
        exc_store_misaligned_i = f[0];
        mret_i                 = m;
        pc_i                   = pc;
        instr_i                = instr;
        badaddr_i              = bad;
        @(negedge clk);
        chk("stall_event_cycle", {31'h0, stall_o}, 32'd1);
        step();
        clear_events();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_o) break;
        end
        chk(name, {31'h0, stall_o}, 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        step();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stall"}, {31'h0, stall_o}, 32'd0);
        chk({name, "_strobes"}, {30'h0, jumpingToMtvec_o, mret_o}, 32'd0);
        chk({name, "_rvalid"}, {31'h0, redirect_valid_o}, 32'd0);
        chk({name, "_rpc"}, redirect_pc_o, 32'h0);
        chk({name, "_fields"}, excCause_o | trapInfo_o | trap_pc_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        clear_events();
        pc_i             = 32'h0;
        instr_i          = 32'h0;
        badaddr_i        = 32'h0;
        mtvec_i          = 32'h205;
        mepc_i           = 32'h0;
        redirect_ready_i = 1'b1;

        // Reset with an event presented: every output must stay 0
        #12;
        instr_valid_i = 1'b1;
        exc_illegal_i = 1'b1;
        #1;
        chk_all_zero("reset");
        clear_events();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Illegal instruction right after release, with latency checks
        push(0, 32'd2, 32'hFFFF_FFFF, 32'h100);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0010000, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        chk("latency_strobe", {31'h0, jumpingToMtvec_o}, 32'd1);
        step();
        @(negedge clk);
        chk("latency_redirect", {31'h0, redirect_valid_o}, 32'd1);
        wait_idle("idle_after_illegal");

        // Interrupt beats ecall
        push(0, 32'h8000_0007, 32'h0, 32'h40);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b1000100, 1'b0, 32'h40, 32'h0000_0073, 32'h0);
        wait_idle("idle_after_irq");

        // Instruction misaligned beats illegal and ebreak
        push(0, 32'd0, 32'h2002, 32'h80);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0111000, 1'b0, 32'h80, 32'hDEAD_BEEF, 32'h2002);
        wait_idle("idle_after_imis");

        // Ebreak beats ecall
        push(0, 32'd3, 32'h0, 32'h84);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0001100, 1'b0, 32'h84, 32'h0010_0073, 32'h0);
        wait_idle("idle_after_ebreak");

        // Ecall beats mret
        push(0, 32'd11, 32'h0, 32'h88);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0000100, 1'b1, 32'h88, 32'h0000_0073, 32'h0);
        wait_idle("idle_after_ecall");

        // Load misaligned beats store misaligned
        push(0, 32'd4, 32'h1003, 32'h500);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0000011, 1'b0, 32'h500, 32'h0, 32'h1003);
        wait_idle("idle_after_load");

        // Store misaligned alone
        push(0, 32'd6, 32'h2001, 32'h504);
        push(2, 32'h0, 32'h0, 32'h204);
        issue(7'b0000001, 1'b0, 32'h504, 32'h0, 32'h2001);
        wait_idle("idle_after_store");

        // MRET with fetch back-pressure for three cycles
        mepc_i           = 32'h300;
        redirect_ready_i = 1'b0;
        push(1, 32'h0, 32'h0, 32'h0);
        push(2, 32'h0, 32'h0, 32'h300);
        issue(7'b0000000, 1'b1, 32'h600, 32'h3020_0073, 32'h0);
        @(negedge clk);
        chk("mret_strobe", {31'h0, mret_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("mret_rvalid_wait", {31'h0, redirect_valid_o}, 32'd1);
            chk("mret_rpc_wait", redirect_pc_o, 32'h300);
            chk("mret_stall_wait", {31'h0, stall_o}, 32'd1);
        end
        step();
        redirect_ready_i = 1'b1;
        @(negedge clk);
        chk("mret_rvalid_fourth", {31'h0, redirect_valid_o}, 32'd1);
        chk("mret_stall_fourth", {31'h0, stall_o}, 32'd1);
        wait_idle("idle_after_mret");

        // Illegal presented during REDIRECT is ignored; mtvec low bits are dropped
        mtvec_i          = 32'h1001;
        redirect_ready_i = 1'b0;
        push(0, 32'd2, 32'h0000_FFFF, 32'h700);
        push(2, 32'h0, 32'h0, 32'h1000);
        issue(7'b0010000, 1'b0, 32'h700, 32'h0000_FFFF, 32'h0);
        step();
        instr_valid_i = 1'b1;
        exc_illegal_i = 1'b1;
        pc_i          = 32'h704;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignore_rvalid", {31'h0, redirect_valid_o}, 32'd1);
            chk("ignore_stall", {31'h0, stall_o}, 32'd1);
            step();
        end
        clear_events();
        redirect_ready_i = 1'b1;
        wait_idle("idle_after_ignore");

        // Reset in the middle of REDIRECT
        redirect_ready_i = 1'b0;
        push(0, 32'd3, 32'h0, 32'h800);
        issue(7'b0001000, 1'b0, 32'h800, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk("pre_reset_rvalid", {31'h0, redirect_valid_o}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst              = 1'b1;
        redirect_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_stall", {31'h0, stall_o}, 32'd0);
            chk("post_reset_rvalid", {31'h0, redirect_valid_o}, 32'd0);
        end
        chk("final_scoreboard", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
